// File: rtl/game_rom_arb_pkg.sv
// Shared defaults, requester naming and index helpers for the game ROM arbiter.
package game_rom_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 16;
    localparam int DW_DEF   = 12;
    localparam int ID_W     = $clog2(NREQ_DEF);

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [ID_W-1:0] {
        TXT_HUD = 2'd0,
        TXT_END = 2'd1,
        PROBE_X = 2'd2,
        PROBE_Y = 2'd3
    } requester_e;

    // Successor of a requester index, wrapping from n-1 back to 0.
    function automatic int nextIndex(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/game_rom_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req_i at or after start_i, wrapping.
module rr_pick
    import game_rom_arb_pkg::*;
#(
    parameter int N = NREQ_DEF
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    output logic [N-1:0]         gnt_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(start_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_rom_arbiter.sv
// Shared synchronous-ROM arbiter with fixed 3-cycle request-to-response latency.
// Define GAME_ROM_ARB_FIXED_PRIO_EN to use fixed priority instead of round-robin.
module game_rom_arbiter
    import game_rom_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    output logic [NREQ-1:0]         gnt,
    output logic [AW-1:0]           rom_addr,
    input  logic [DW-1:0]           rom_rdata,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DW-1:0]           rsp_data
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   romAddr_q, romAddr_d;
    logic [IW-1:0]   lastGnt_q, lastGnt_d;
    logic            tagVld1_q, tagVld1_d, tagVld2_q, tagVld2_d;
    logic [IW-1:0]   tagId1_q, tagId1_d, tagId2_q, tagId2_d;
    logic [NREQ-1:0] rspValid_q, rspValid_d;
    logic [IW-1:0]   rspId_q, rspId_d;
    logic [DW-1:0]   rspData_q, rspData_d;

    logic [NREQ-1:0] eligible, pick;
    logic            pickValid;
    logic [IW-1:0]   startIdx, pickIdx;

    // The requester currently holding gnt sits out this cycle's arbitration.
    assign eligible = req & ~gnt_q;

`ifdef GAME_ROM_ARB_FIXED_PRIO_EN
    assign startIdx = '0;
`else
    assign startIdx = IW'(nextIndex(int'(lastGnt_q), NREQ));
`endif

    rr_pick #(.N(NREQ)) u_pick (
        .req_i  (eligible),
        .start_i(startIdx),
        .gnt_o  (pick),
        .valid_o(pickValid)
    );

    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pickIdx = IW'(i);
        end
    end

    // Tag pipe carries the winner index alongside the ROM read so the response
    // never depends on the (possibly changed) request vector.
    always_comb begin
        gnt_d      = pick;
        romAddr_d  = pickValid ? req_addr[int'(pickIdx)*AW +: AW] : romAddr_q;
        lastGnt_d  = pickValid ? pickIdx : lastGnt_q;
        tagVld1_d  = pickValid;
        tagId1_d   = pickIdx;
        tagVld2_d  = tagVld1_q;
        tagId2_d   = tagId1_q;
        rspValid_d = '0;
        if (tagVld2_q) rspValid_d[tagId2_q] = 1'b1;
        rspId_d    = tagVld2_q ? tagId2_q : rspId_q;
        rspData_d  = tagVld2_q ? rom_rdata : rspData_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            romAddr_q  <= '0;
            lastGnt_q  <= IW'(NREQ - 1);
            tagVld1_q  <= 1'b0;
            tagVld2_q  <= 1'b0;
            tagId1_q   <= '0;
            tagId2_q   <= '0;
            rspValid_q <= '0;
            rspId_q    <= '0;
            rspData_q  <= '0;
        end else begin
            gnt_q      <= gnt_d;
            romAddr_q  <= romAddr_d;
            lastGnt_q  <= lastGnt_d;
            tagVld1_q  <= tagVld1_d;
            tagVld2_q  <= tagVld2_d;
            tagId1_q   <= tagId1_d;
            tagId2_q   <= tagId2_d;
            rspValid_q <= rspValid_d;
            rspId_q    <= rspId_d;
            rspData_q  <= rspData_d;
        end
    end

    assign gnt       = gnt_q;
    assign rom_addr  = romAddr_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;

endmodule

// File: tb/tb_game_rom_arbiter.sv
// Directed self-checking bench for game_rom_arbiter with a synchronous ROM model.
// Expectations follow GAME_ROM_ARB_FIXED_PRIO_EN when it is defined.
module tb_game_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] reqAddr;
    logic [3:0]  gnt;
    logic [15:0] rom_addr;
    logic [11:0] rom_rdata = '0;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_data;

    int total = 0;
    int bad   = 0;
    logic [15:0] addrTab [4];

    game_rom_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (reqAddr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_rdata(rom_rdata),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] romWord(input logic [15:0] a);
        return a[11:0] ^ {a[15:12], 8'h3C};
    endfunction

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) rom_rdata <= romWord(rom_addr);

    function automatic int expGrant(input int k);
`ifdef GAME_ROM_ARB_FIXED_PRIO_EN
        return k % 2;
`else
        return k % 4;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic setAddr(input int i, input logic [15:0] a);
        reqAddr[i*16 +: 16] = a;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        applyStimulus(4'b0000);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int g, r, cnt;

    initial begin
        rst = 1'b1;
        req = '0;
        reqAddr = '0;
        addrTab[0] = 16'h0A10;
        addrTab[1] = 16'h1B21;
        addrTab[2] = 16'h2C32;
        addrTab[3] = 16'h3D43;
        tick();
        tick();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_rspv", rsp_valid, 0);
        checkOutput("rst_addr", rom_addr, 0);
        checkOutput("rst_data", rsp_data, 0);
        checkOutput("rst_id", rsp_id, 0);

        // Single req[2] pulse.
        doReset();
        setAddr(2, 16'h0123);
        applyStimulus(4'b0100);
        tick();
        checkOutput("t1_gnt", gnt, 4'b0100);
        checkOutput("t1_addr", rom_addr, 16'h0123);
        applyStimulus(4'b0000);
        tick();
        checkOutput("t1_gnt_off", gnt, 0);
        checkOutput("t1_rspv_early", rsp_valid, 0);
        tick();
        checkOutput("t1_rspv", rsp_valid, 4'b0100);
        checkOutput("t1_id", rsp_id, 2);
        checkOutput("t1_data", rsp_data, romWord(16'h0123));
        tick();
        checkOutput("t1_rspv_off", rsp_valid, 0);
        checkOutput("t1_data_hold", rsp_data, romWord(16'h0123));
        checkOutput("t1_addr_hold", rom_addr, 16'h0123);
        checkOutput("t1_id_hold", rsp_id, 2);

        // All four requesters held high.
        doReset();
        for (int i = 0; i < 4; i++) setAddr(i, addrTab[i]);
        applyStimulus(4'b1111);
        for (int k = 0; k < 12; k++) begin
            tick();
            g = expGrant(k);
            checkOutput("t2_gnt", gnt, 1 << g);
            checkOutput("t2_addr", rom_addr, addrTab[g]);
            if (k >= 2) begin
                r = expGrant(k - 2);
                checkOutput("t2_rspv", rsp_valid, 1 << r);
                checkOutput("t2_id", rsp_id, r);
                checkOutput("t2_data", rsp_data, romWord(addrTab[r]));
            end else begin
                checkOutput("t2_rspv_early", rsp_valid, 0);
            end
        end
        applyStimulus(4'b0000);
        tick();
        tick();
        tick();

        // Lone requester 1 held for 10 cycles.
        doReset();
        applyStimulus(4'b0010);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("t3_gnt", gnt, (k % 2 == 0) ? 4'b0010 : 4'b0000);
            if (gnt[1]) cnt++;
            if (k == 8) applyStimulus(4'b0000);
        end
        tick();
        checkOutput("t3_gnt_end", gnt, 0);
        checkOutput("t3_count", cnt, 5);
        tick();
        tick();

        // Requester 3 withdrawn just before its turn.
        doReset();
        applyStimulus(4'b1011);
        tick();
        checkOutput("t4_gnt0", gnt, 4'b0001);
        tick();
        checkOutput("t4_gnt1", gnt, 4'b0010);
        applyStimulus(4'b0011);
        tick();
        checkOutput("t4_gnt_next", gnt, 4'b0001);
        tick();
        checkOutput("t4_gnt_after", gnt, 4'b0010);
        applyStimulus(4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("t4_gnt3", gnt[3], 0);
            checkOutput("t4_rsp3", rsp_valid[3], 0);
            if (k == 0) checkOutput("t4_rsp_k0", rsp_valid, 4'b0001);
        end

        // Reset one cycle after gnt[0] drops the in-flight read.
        doReset();
        setAddr(0, 16'h0BEE);
        applyStimulus(4'b0001);
        tick();
        checkOutput("t5_gnt", gnt, 4'b0001);
        applyStimulus(4'b0000);
        tick();
        rst = 1'b1;
        checkOutput("t5_rspv_a", rsp_valid, 0);
        tick();
        checkOutput("t5_rspv_b", rsp_valid, 0);
        checkOutput("t5_gnt_rst", gnt, 0);
        tick();
        rst = 1'b0;
        checkOutput("t5_rspv_c", rsp_valid, 0);
        applyStimulus(4'b1111);
        tick();
        checkOutput("t5_rspv_d", rsp_valid, 0);
        checkOutput("t5_first", gnt, 4'b0001);
        applyStimulus(4'b0000);
        tick();
        tick();
        tick();

        // Requesters 0 and 3 held: exclusion forces alternation.
        doReset();
        applyStimulus(4'b1001);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("t6_gnt", gnt, (k % 2 == 0) ? 4'b0001 : 4'b1000);
            if (gnt[3]) cnt++;
        end
        checkOutput("t6_count3", cnt, 4);
        applyStimulus(4'b0000);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_rom_arbiter.md
GAME_ROM_ARBITER -- requirements
Module: game_rom_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 16, ROM address width.
REQ-003 SHALL have parameter DW, default 12, ROM data width (rgb444).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NREQ  per-requester read request, held until granted or withdrawn.
REQ-007 SHALL have port req_addr  input  NREQ*AW  packed addresses, slice i belongs to req[i], stable while req[i] high.
REQ-008 SHALL have port gnt  output  NREQ  one-hot, one-cycle grant pulse.
REQ-009 SHALL have port rom_addr  output  AW  address to the shared synchronous ROM port.
REQ-010 SHALL have port rom_rdata  input  DW  ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have port rsp_valid  output  NREQ  one-hot, one-cycle response strobe.
REQ-012 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester owning rsp_data.
REQ-013 SHALL have port rsp_data  output  DW  returned ROM word.

Function
- REQ-014 SHALL arbitrate every cycle; at most one gnt bit set per cycle.
- REQ-015 SHALL register gnt and rom_addr on the same edge: request in cycle N gives gnt[i] and rom_addr=req_addr[i] in cycle N+1.
- REQ-016 SHALL register rom_rdata into rsp_data with rsp_valid[i] and rsp_id=i in cycle N+3, giving fixed 3-cycle req-to-rsp latency.
- REQ-017 SHALL exclude the requester whose gnt is high in the current cycle from that cycle's arbitration, so no requester is granted on back-to-back cycles.
- REQ-018 SHALL sustain one grant per cycle in aggregate when two or more eligible requesters exist; a lone continuous requester SHALL be granted every second cycle.
- REQ-019 SHALL use round-robin arbitration: search starts at last_granted+1 and wraps from NREQ-1 to 0.
- REQ-020 SHALL treat a req dropped before grant as withdrawn, with no grant and no response.
- REQ-021 SHALL hold rom_addr and rsp_data at their last values when idle; rsp_id SHALL change only with rsp_valid.
- REQ-022 SHALL pipeline the requester index alongside the ROM read (2-stage tag pipe), never recomputing it from req.

Reset
- REQ-023 SHALL clear gnt, rsp_valid, rom_addr, rsp_data, rsp_id and the tag pipe to 0, and set last_granted to NREQ-1 so requester 0 wins first.
- REQ-024 SHALL discard in-flight reads on reset mid-operation; no rsp_valid for any cycle while rst is high or in the first cycle after its release.

Configuration
- REQ-025 SHALL, with macro GAME_ROM_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority (lowest eligible index wins; REQ-017 exclusion still applies); without it, REQ-019 round-robin SHALL apply.

Structure
- REQ-026 SHALL take NREQ/AW/DW defaults, the requester-id typedef and named requester indices (TXT_HUD=0, TXT_END=1, PROBE_X=2, PROBE_Y=3) from package game_rom_arb_pkg.
- REQ-027 SHALL contain one sub-module, rr_pick (rotating priority encoder: req vector, start index -> one-hot winner plus valid).

Verification
- REQ-028 SHALL check a single req[2] pulse with addr 0x0123: gnt[2] in N+1, rom_addr=0x0123, rsp_valid[2]/rsp_id=2 in N+3 with the ROM model word.
- REQ-029 SHALL check all four req held high after reset: grants 0,1,2,3,0,... one per cycle, and responses in the same order each 3 cycles later.
- REQ-030 SHALL check req[1] alone held high for 10 cycles: gnt[1] on alternate cycles, 5 grants.
- REQ-031 SHALL check req[3] withdrawn in the cycle before it would win: no gnt[3], no rsp_valid[3], and the next eligible requester granted.
- REQ-032 SHALL check rst asserted one cycle after gnt[0]: no rsp_valid during or one cycle after reset, then first grant goes to requester 0.
- REQ-033 SHALL check, with GAME_ROM_ARB_FIXED_PRIO_EN defined, req 0 and 3 held high: grants alternate 0,3,0,3 under exclusion and requester 3 is never starved.
